// File: rtl/mul_exp_arb.sv
// Round-robin arbiter in front of one shared, fixed-latency mul_exp unit.
// Grants at most one requester per cycle, muxes its operands onto the unit,
// and tracks the owner of every in-flight op with a {valid, tag} pipeline
// whose depth equals the unit latency so results route back to their owner.
module mul_exp_arb #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2,
  parameter int LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [4*N_REQ-1:0]   req_exp1,
  input  logic [4*N_REQ-1:0]   req_exp2,
  output logic [3:0]           mul_exp1,
  output logic [3:0]           mul_exp2,
  input  logic [3:0]           mul_result,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [3:0]           rsp_data,
  output logic                 idle
);

  logic [TAG_W-1:0]            ptr;
  logic [TAG_W-1:0]            win;
  logic                        grant;
  logic [LAT-1:0]              vld_pipe;
  logic [LAT-1:0][TAG_W-1:0]   tag_pipe;

  // Search from the pointer upward with wrap; first valid requester wins.
  always_comb begin
    logic [TAG_W:0]   sum;
    logic [TAG_W-1:0] cand;
    grant = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (TAG_W+1)'(k);
      if (sum >= (TAG_W+1)'(N_REQ)) sum = sum - (TAG_W+1)'(N_REQ);
      cand = TAG_W'(sum);
      if (en && !grant && req_valid[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
    end
  end

  // One-hot ready and winner operands; zeros on the unit when nothing issues.
  always_comb begin
    req_ready = '0;
    mul_exp1  = 4'h0;
    mul_exp2  = 4'h0;
    if (grant) begin
      req_ready[win] = 1'b1;
      mul_exp1 = req_exp1[{win, 2'b00} +: 4];
      mul_exp2 = req_exp2[{win, 2'b00} +: 4];
    end
  end

  // Pointer moves just past the winner on every transfer, else holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (grant)
      ptr <= (win == TAG_W'(N_REQ-1)) ? '0 : win + 1'b1;
  end

  // Owner tag shift register, aligned with the unit's internal pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= grant;
      tag_pipe[0] <= win;
      for (int s = 1; s < LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  // Response strobe and data come straight off the last stage.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = 4'h0;
    if (vld_pipe[LAT-1]) begin
      rsp_valid = N_REQ'(1) << tag_pipe[LAT-1];
      rsp_data  = mul_result;
    end
  end

  // Idle only when nobody is asking and nothing is in flight.
  always_comb idle = ~|req_valid & ~|vld_pipe;

endmodule

// File: tb/tb_mul_exp_arb.sv
// Directed bench for mul_exp_arb. A two-stage stand-in for the shared unit
// computes f(a,b) = 3a + 5b + 1 (mod 16), which yields the reference results
// f(3,4)=E, f(1,1)=9, f(0,0)=1 used in the expected values below.
module tb_mul_exp_arb;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [4*N-1:0] req_exp1, req_exp2;
  logic [3:0]   mul_exp1, mul_exp2, mul_result;
  logic [N-1:0] rsp_valid;
  logic [3:0]   rsp_data;
  logic         idle;

  int tests = 0;
  int fails = 0;
  int npulse;

  logic [3:0] s1, s2;

  mul_exp_arb #(.N_REQ(N), .TAG_W(2), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_exp1(req_exp1), .req_exp2(req_exp2),
    .mul_exp1(mul_exp1), .mul_exp2(mul_exp2), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] f(input logic [3:0] a, input logic [3:0] b);
    return 4'(3*int'(a) + 5*int'(b) + 1);
  endfunction

  // Stand-in shared unit: operands captured at edge 1, result out after edge 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 4'h0;
      s2 <= 4'h0;
    end else begin
      s1 <= f(mul_exp1, mul_exp2);
      s2 <= s1;
    end
  end
  assign mul_result = s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    en = 1'b1;
    #1;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_data [4];
    exp_data[0] = 4'h9; exp_data[1] = 4'h1; exp_data[2] = 4'hE; exp_data[3] = 4'h9;
    rst_n = 1'b0; en = 1'b1; req_valid = '0; req_exp1 = '0; req_exp2 = '0;
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_idle", 32'(idle), 1);

    // 1: lone request from requester 1
    do_reset; tick;
    req_exp1[7:4] = 4'd3; req_exp2[7:4] = 4'd4; req_valid = 4'b0010; #1;
    chk("t1_ready", 32'(req_ready), 32'b0010);
    chk("t1_mul_exp1", 32'(mul_exp1), 3);
    chk("t1_mul_exp2", 32'(mul_exp2), 4);
    tick; req_valid = '0; #1;
    chk("t1_rsp_early", 32'(rsp_valid), 0);
    chk("t1_idle_busy", 32'(idle), 0);
    tick; #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'b0010);
    chk("t1_rsp_data", 32'(rsp_data), 32'hE);
    tick; #1;
    chk("t1_idle_after", 32'(idle), 1);
    chk("t1_rsp_after", 32'(rsp_valid), 0);

    // 2: all four streaming, round robin from pointer 0
    do_reset; tick;
    req_exp1 = {4'd1, 4'd3, 4'd0, 4'd1};
    req_exp2 = {4'd1, 4'd4, 4'd0, 4'd1};
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'(1) << (c % 4));
      if (c >= 2) begin
        chk($sformatf("t2_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(1) << ((c-2) % 4));
        chk($sformatf("t2_rsp_data_c%0d", c), 32'(rsp_data), 32'(exp_data[(c-2) % 4]));
      end
      tick;
    end
    req_valid = '0; #1;
    chk("t2_tail0_valid", 32'(rsp_valid), 32'b0001);
    chk("t2_tail0_data", 32'(rsp_data), 32'h9);
    tick; #1;
    chk("t2_tail1_valid", 32'(rsp_valid), 32'b0010);
    chk("t2_tail1_data", 32'(rsp_data), 32'h1);
    tick; #1;
    chk("t2_idle", 32'(idle), 1);

    // 3: pointer at 1, requesters 0 and 3 -> 3 first, then 0
    do_reset; tick;
    req_exp1 = '0; req_exp2 = '0;
    req_valid = 4'b0001; #1;
    chk("t3_prime", 32'(req_ready), 32'b0001);
    tick; req_valid = 4'b1001; #1;
    chk("t3_first", 32'(req_ready), 32'b1000);
    tick; req_valid = 4'b0001; #1;
    chk("t3_second", 32'(req_ready), 32'b0001);
    chk("t3_rsp_prime", 32'(rsp_valid), 32'b0001);
    tick; req_valid = 4'b1111; #1;
    chk("t3_ptr_is_1", 32'(req_ready), 32'b0010);
    chk("t3_rsp_first", 32'(rsp_valid), 32'b1000);
    tick; req_valid = '0; #1;
    chk("t3_rsp_second", 32'(rsp_valid), 32'b0001);
    chk("t3_rsp_data", 32'(rsp_data), 32'h1);
    tick; #1;
    chk("t3_rsp_third", 32'(rsp_valid), 32'b0010);
    tick; tick;

    // 4: en dropped after two grants, then resumed
    do_reset; tick;
    npulse = 0;
    req_valid = 4'b1111; #1;
    chk("t4_g0", 32'(req_ready), 32'b0001);
    tick; req_valid = 4'b1110; #1;
    chk("t4_g1", 32'(req_ready), 32'b0010);
    tick; req_valid = 4'b1100; en = 1'b0; #1;
    chk("t4_off_ready0", 32'(req_ready), 0);
    chk("t4_rsp0", 32'(rsp_valid), 32'b0001);
    if (rsp_valid != '0) npulse++;
    tick; #1;
    chk("t4_off_ready1", 32'(req_ready), 0);
    chk("t4_rsp1", 32'(rsp_valid), 32'b0010);
    if (rsp_valid != '0) npulse++;
    tick; #1;
    chk("t4_idle_pending", 32'(idle), 0);
    if (rsp_valid != '0) npulse++;
    tick; #1;
    chk("t4_idle_pending2", 32'(idle), 0);
    if (rsp_valid != '0) npulse++;
    chk("t4_pulse_count", 32'(npulse), 2);
    tick; en = 1'b1; #1;
    chk("t4_resume", 32'(req_ready), 32'b0100);
    tick; req_valid = 4'b1000; #1;
    chk("t4_resume2", 32'(req_ready), 32'b1000);
    tick; req_valid = '0; #1;
    chk("t4_rsp2", 32'(rsp_valid), 32'b0100);
    tick; #1;
    chk("t4_rsp3", 32'(rsp_valid), 32'b1000);
    tick; #1;
    chk("t4_idle_end", 32'(idle), 1);

    // 5: reset one cycle after a grant discards the op
    do_reset; tick;
    req_valid = 4'b0010; #1;
    chk("t5_grant", 32'(req_ready), 32'b0010);
    tick; req_valid = '0; rst_n = 1'b0; #1;
    chk("t5_rst_rsp", 32'(rsp_valid), 0);
    chk("t5_rst_data", 32'(rsp_data), 0);
    chk("t5_rst_idle", 32'(idle), 1);
    chk("t5_rst_ready", 32'(req_ready), 0);
    tick; rst_n = 1'b1; #1;
    chk("t5_no_rsp_a", 32'(rsp_valid), 0);
    tick; #1;
    chk("t5_no_rsp_b", 32'(rsp_valid), 0);
    req_valid = 4'b1111; #1;
    chk("t5_ptr_zero", 32'(req_ready), 32'b0001);
    req_valid = '0;

    // 6: requester 2 withdraws before any grant
    do_reset; tick;
    en = 1'b0; req_valid = 4'b0100; #1;
    chk("t6_no_grant", 32'(req_ready), 0);
    chk("t6_idle_pending", 32'(idle), 0);
    tick; req_valid = '0; en = 1'b1; #1;
    chk("t6_no_grant2", 32'(req_ready), 0);
    chk("t6_idle", 32'(idle), 1);
    for (int c = 0; c < 3; c++) begin
      tick; #1;
      chk($sformatf("t6_no_rsp_%0d", c), 32'(rsp_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_exp_arb.md
Name: mul_exp_arb

Overview:
Round-robin arbiter that shares one pipelined mul_exp unit (fixed 2-cycle latency, 4-bit exponent operands) among N_REQ requesters. It grants at most one request per cycle, drives the winner's operands to the unit, and carries a tag pipeline matched to the unit latency. Each result is returned to the requester that issued it. It sits between the per-lane quantized MAC front-ends and the shared exponent datapath. An enable input allows a clean drain before reconfiguration.

Parameters:
N_REQ, 4, number of requesters (2..8)
TAG_W, 2, requester index width; must equal clog2(N_REQ)
LAT, 2, pipeline latency of the shared unit in clock edges (operand-in to result-valid)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  issue enable; 0 = grant nothing new, in-flight ops complete
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester grant (one-hot or zero)
req_exp1  in  4*N_REQ  operand A, requester i at [4i+3:4i]
req_exp2  in  4*N_REQ  operand B, same packing
mul_exp1  out  4  operand A to shared unit
mul_exp2  out  4  operand B to shared unit
mul_result  in  4  result from shared unit
rsp_valid  out  N_REQ  one-hot, one-cycle result strobe to the owning requester
rsp_data  out  4  result data, valid when any rsp_valid bit is set
idle  out  1  1 when no request is pending and the pipeline is empty

Behaviour:
- Reset: the round-robin pointer is 0, all tag-pipeline stages are invalid, rsp_valid = 0, rsp_data = 0, idle = 1.
- Arbitration (combinational in cycle T):
  - When en=1, search req_valid starting at the pointer, ascending with wrap. The first set bit i wins and req_ready = 1<<i.
  - When en=0 or no request is valid, req_ready = 0.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. A requester holds valid and operands stable until it is granted. Dropping valid before a grant is legal and has no effect.
- Pointer update: on a transfer to i, pointer <= (i+1) mod N_REQ at the edge. With no transfer, the pointer holds. No requester waits more than N_REQ-1 grants.
- Operand mux: mul_exp1/mul_exp2 = the winner's operands during a transfer, otherwise 4'h0.
- Tag pipeline:
  - LAT-stage shift register of {valid, tag}. Stage 0 loads {transfer, winner index} at each edge.
  - The last stage drives rsp_valid = valid ? (1<<tag) : 0 and rsp_data = valid ? mul_result : 4'h0. Both outputs are registered-aligned with mul_result (combinational from the last stage).
- Latency: a request granted in cycle T returns rsp_valid in cycle T+LAT. Throughput is 1 op/cycle. Back-to-back grants produce back-to-back responses in grant order.
- No response backpressure: a requester must accept rsp_valid on the cycle it is strobed.
- en deassert mid-stream: no new grants from the next comb evaluation. Ops already issued still return after LAT cycles. en reassert resumes from the held pointer.
- idle = ~|req_valid & ~|(pipeline valid bits). Requests pending while en=0 keep idle=0.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced. The shared unit is reset by the same rst_n.
- A single requester re-granted on consecutive cycles is legal; the pointer wraps past it each time.

Test Plan:
1. Reset, then req 1 alone with exp1=3, exp2=4 -> req_ready=4'b0010 in cycle T; rsp_valid=4'b0010 and rsp_data=4'hE in T+2; idle=1 at T+3.
2. All four requesters valid continuously, pointer=0, operands (1,1),(0,0),(3,4),(1,1) -> grants 0,1,2,3,0… on successive cycles. Responses 9,1,E,9 are strobed to 0,1,2,3 at T+2..T+5.
3. Req 0 and req 3 valid, pointer=1 -> req 3 granted first, then req 0. Pointer ends at 1.
4. Four requests streaming, en dropped after two grants -> exactly two rsp_valid pulses. idle stays 0 while requests are pending. Re-enable resumes at the next index in round-robin order.
5. rst_n asserted one cycle after a grant -> no rsp_valid afterwards; all outputs at reset values; pointer=0.
6. Requester 2 drops valid before being granted (others idle) -> no grant and no response to it; idle=1 once req_valid=0.
